id_stage_pipe: RTL and testbench

- Parametrised decode stage for the pipelined LC-3b core.
- Takes decoded instruction fields from the control ROM and reads the register file; a write-through bypass from writeback applies to those reads.
- Detects load-use hazards against the instruction in EX and inserts bubbles, then registers everything into the ID/EX pipeline register with stall and flush control.
- Successor to the combinational decode datapath: adds the ID/EX register, hazard handling, a bypass, and configurable width, depth and control width.

---
 rtl/id_stage_pipe.sv | 199 +++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe
// Decode stage of the pipelined LC-3b core. Selects register-file read
// addresses from the decoded fields and reads the register file through a
// write-through bypass from writeback. It detects a load-use hazard against
// the instruction in EX and inserts a one-cycle bubble. Everything is
// registered into the ID/EX pipeline register, which has flush and stall
// control.
// Optional build macro: ID_PERF_CNT_EN adds the saturating counters
// perf_stall_cnt and perf_bubble_cnt.
module id_stage_pipe #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 8,
  parameter int CTRL_W    = 32,
  localparam int RA_W     = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RA_W-1:0]   in_dest,
  input  logic [RA_W-1:0]   in_sr1,
  input  logic [RA_W-1:0]   in_sr2,
  input  logic              in_dest_link,
  input  logic              in_store_sel,
  input  logic              in_uses_a,
  input  logic              in_uses_b,
  input  logic              in_writes_dest,
  input  logic              in_mem_read,
  output logic              id_stall,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              wb_load,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt,
`endif
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [RA_W-1:0]   ex_dest,
  output logic              ex_writes_dest,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_a_data,
  output logic [DATA_W-1:0] ex_b_data
);

  // JSR/TRAP write their return address into the top register.
  localparam logic [RA_W-1:0] LINK_REG = RA_W'(REG_COUNT - 1);

  // True when a consumed operand reads the register the EX load produces.
  function automatic logic src_hit(input logic uses,
                                   input logic [RA_W-1:0] addr,
                                   input logic [RA_W-1:0] dest);
    return uses & (addr == dest);
  endfunction

  // Bypass mux: a same-cycle writeback to the read address wins over the array.
  function automatic logic [DATA_W-1:0] bypass_read(input logic              wen,
                                                    input logic [RA_W-1:0]   waddr,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic [RA_W-1:0]   raddr,
                                                    input logic [DATA_W-1:0] rdata);
    return (wen && (waddr == raddr)) ? wdata : rdata;
  endfunction

  logic [DATA_W-1:0] rf_r [REG_COUNT];

  logic [RA_W-1:0]   addr_a_s;
  logic [RA_W-1:0]   addr_b_s;
  logic [RA_W-1:0]   dest_res_s;
  logic [DATA_W-1:0] a_data_s;
  logic [DATA_W-1:0] b_data_s;
  logic              hz_s;
  logic              id_stall_s;
  logic              bubble_s;
  logic [CTRL_W-1:0] cap_ctrl_s;
  logic              cap_writes_s;
  logic              cap_mem_read_s;

  logic              ex_valid_r;
  logic [CTRL_W-1:0] ex_ctrl_r;
  logic [RA_W-1:0]   ex_dest_r;
  logic              ex_writes_dest_r;
  logic              ex_mem_read_r;
  logic [DATA_W-1:0] ex_a_data_r;
  logic [DATA_W-1:0] ex_b_data_r;

  // Operand address selection and destination resolution.
  always_comb begin
    addr_a_s   = in_store_sel ? in_dest : in_sr1;
    addr_b_s   = in_sr2;
    dest_res_s = in_dest_link ? LINK_REG : in_dest;
  end

  // Register-file reads through the writeback bypass.
  always_comb begin
    a_data_s = bypass_read(wb_load, wb_addr, wb_data, addr_a_s, rf_r[addr_a_s]);
    b_data_s = bypass_read(wb_load, wb_addr, wb_data, addr_b_s, rf_r[addr_b_s]);
  end

  // Load-use hazard against EX, and the resulting decode stall.
  always_comb begin
    hz_s = in_valid & ex_valid_r & ex_mem_read_r & ex_writes_dest_r &
           (src_hit(in_uses_a, addr_a_s, ex_dest_r) |
            src_hit(in_uses_b, addr_b_s, ex_dest_r));
    id_stall_s = hz_s | ex_stall;
    // A bubble is inserted only when neither flush nor ex_stall takes priority.
    bubble_s   = hz_s & ~flush & ~ex_stall;
  end

  // Values captured into ID/EX; an empty slot carries no control or flags.
  always_comb begin
    if (in_valid) begin
      cap_ctrl_s     = in_ctrl;
      cap_writes_s   = in_writes_dest;
      cap_mem_read_s = in_mem_read;
    end else begin
      cap_ctrl_s     = {CTRL_W{1'b0}};
      cap_writes_s   = 1'b0;
      cap_mem_read_s = 1'b0;
    end
  end

  // Register-file write from writeback; stall and flush do not block it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_load) begin
      rf_r[wb_addr] <= wb_data;
    end
  end

  // ID/EX pipeline register: flush, then stall-hold, then bubble, then capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_r       <= 1'b0;
      ex_ctrl_r        <= {CTRL_W{1'b0}};
      ex_dest_r        <= {RA_W{1'b0}};
      ex_writes_dest_r <= 1'b0;
      ex_mem_read_r    <= 1'b0;
      ex_a_data_r      <= {DATA_W{1'b0}};
      ex_b_data_r      <= {DATA_W{1'b0}};
    end else if (flush || (!ex_stall && hz_s)) begin
      // Squash or bubble: kill the slot; destination and data simply hold.
      ex_valid_r       <= 1'b0;
      ex_ctrl_r        <= {CTRL_W{1'b0}};
      ex_writes_dest_r <= 1'b0;
      ex_mem_read_r    <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid_r       <= in_valid;
      ex_ctrl_r        <= cap_ctrl_s;
      ex_dest_r        <= dest_res_s;
      ex_writes_dest_r <= cap_writes_s;
      ex_mem_read_r    <= cap_mem_read_s;
      ex_a_data_r      <= a_data_s;
      ex_b_data_r      <= b_data_s;
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_r;
  logic [31:0] perf_bubble_cnt_r;

  // Saturating counters of stalled cycles and inserted hazard bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt_r  <= 32'd0;
      perf_bubble_cnt_r <= 32'd0;
    end else begin
      if (id_stall_s && (perf_stall_cnt_r != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
      end
      if (bubble_s && (perf_bubble_cnt_r != 32'hFFFF_FFFF)) begin
        perf_bubble_cnt_r <= perf_bubble_cnt_r + 32'd1;
      end
    end
  end

  assign perf_stall_cnt  = perf_stall_cnt_r;
  assign perf_bubble_cnt = perf_bubble_cnt_r;
`else
  // Without the counters the bubble qualifier has no consumer.
  logic unused_bubble_s;
  assign unused_bubble_s = bubble_s;
`endif

  assign id_stall       = id_stall_s;
  assign ex_valid       = ex_valid_r;
  assign ex_ctrl        = ex_ctrl_r;
  assign ex_dest        = ex_dest_r;
  assign ex_writes_dest = ex_writes_dest_r;
  assign ex_mem_read    = ex_mem_read_r;
  assign ex_a_data      = ex_a_data_r;
  assign ex_b_data      = ex_b_data_r;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed vector table, hand-written
// stall/reset sequences, a random run against a reference model, and a
// wide-configuration instance.
module tb_id_stage_pipe;

  localparam int DW = 16;
  localparam int CW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [AW-1:0] in_dest, in_sr1, in_sr2;
  logic          in_dest_link, in_store_sel, in_uses_a, in_uses_b;
  logic          in_writes_dest, in_mem_read;
  logic          id_stall, ex_stall, flush, wb_load;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          ex_valid, ex_writes_dest, ex_mem_read;
  logic [CW-1:0] ex_ctrl;
  logic [AW-1:0] ex_dest;
  logic [DW-1:0] ex_a_data, ex_b_data;

  // Wide instance: DATA_W=32, REG_COUNT=16, CTRL_W=8.
  logic        p_in_valid;
  logic [7:0]  p_in_ctrl;
  logic [3:0]  p_in_dest, p_in_sr1, p_in_sr2;
  logic        p_in_dest_link, p_in_store_sel, p_in_uses_a, p_in_uses_b;
  logic        p_in_writes_dest, p_in_mem_read;
  logic        p_id_stall, p_ex_stall, p_flush, p_wb_load;
  logic [3:0]  p_wb_addr;
  logic [31:0] p_wb_data;
  logic        p_ex_valid, p_ex_writes_dest, p_ex_mem_read;
  logic [7:0]  p_ex_ctrl;
  logic [3:0]  p_ex_dest;
  logic [31:0] p_ex_a_data, p_ex_b_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_stage_pipe u_dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_dest(in_dest), .in_sr1(in_sr1), .in_sr2(in_sr2),
    .in_dest_link(in_dest_link), .in_store_sel(in_store_sel),
    .in_uses_a(in_uses_a), .in_uses_b(in_uses_b),
    .in_writes_dest(in_writes_dest), .in_mem_read(in_mem_read),
    .id_stall(id_stall), .ex_stall(ex_stall), .flush(flush),
    .wb_load(wb_load), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_dest(ex_dest),
    .ex_writes_dest(ex_writes_dest), .ex_mem_read(ex_mem_read),
    .ex_a_data(ex_a_data), .ex_b_data(ex_b_data)
  );

  id_stage_pipe #(.DATA_W(32), .REG_COUNT(16), .CTRL_W(8)) u_dut_wide (
    .clk(clk), .reset(rst), .in_valid(p_in_valid), .in_ctrl(p_in_ctrl),
    .in_dest(p_in_dest), .in_sr1(p_in_sr1), .in_sr2(p_in_sr2),
    .in_dest_link(p_in_dest_link), .in_store_sel(p_in_store_sel),
    .in_uses_a(p_in_uses_a), .in_uses_b(p_in_uses_b),
    .in_writes_dest(p_in_writes_dest), .in_mem_read(p_in_mem_read),
    .id_stall(p_id_stall), .ex_stall(p_ex_stall), .flush(p_flush),
    .wb_load(p_wb_load), .wb_addr(p_wb_addr), .wb_data(p_wb_data),
    .ex_valid(p_ex_valid), .ex_ctrl(p_ex_ctrl), .ex_dest(p_ex_dest),
    .ex_writes_dest(p_ex_writes_dest), .ex_mem_read(p_ex_mem_read),
    .ex_a_data(p_ex_a_data), .ex_b_data(p_ex_b_data)
  );

  typedef struct {
    logic          wbl;
    logic [AW-1:0] wba;
    logic [DW-1:0] wbd;
    logic          vld;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] dest, sr1, sr2;
    logic          link, ssel, ua, ub, wd, mr, stl, fl;
    logic          e_stall, e_valid;
    logic [AW-1:0] e_dest;
    logic [DW-1:0] e_a, e_b;
  } vec_t;

  vec_t tv [10];

  // Reference model state (register contents and the ID/EX slot).
  logic [DW-1:0] m_rf [8];
  logic          m_valid, m_wd, m_mr;
  logic [CW-1:0] m_ctrl;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_a, m_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_ctrl = 32'd0; in_dest = 3'd0; in_sr1 = 3'd0; in_sr2 = 3'd0;
    in_dest_link = 1'b0; in_store_sel = 1'b0; in_uses_a = 1'b0; in_uses_b = 1'b0;
    in_writes_dest = 1'b0; in_mem_read = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    wb_load = 1'b0; wb_addr = 3'd0; wb_data = 16'd0;
  endtask

  task automatic drive_vec(input vec_t v);
    wb_load = v.wbl; wb_addr = v.wba; wb_data = v.wbd;
    in_valid = v.vld; in_ctrl = v.ctrl; in_dest = v.dest; in_sr1 = v.sr1; in_sr2 = v.sr2;
    in_dest_link = v.link; in_store_sel = v.ssel; in_uses_a = v.ua; in_uses_b = v.ub;
    in_writes_dest = v.wd; in_mem_read = v.mr; ex_stall = v.stl; flush = v.fl;
  endtask

  initial begin
    logic [AW-1:0] aa;
    logic          hz;
    logic [DW-1:0] ra, rb;

    clear_inputs();
    p_in_valid = 1'b0; p_in_ctrl = 8'd0; p_in_dest = 4'd0; p_in_sr1 = 4'd0; p_in_sr2 = 4'd0;
    p_in_dest_link = 1'b0; p_in_store_sel = 1'b0; p_in_uses_a = 1'b0; p_in_uses_b = 1'b0;
    p_in_writes_dest = 1'b0; p_in_mem_read = 1'b0; p_ex_stall = 1'b0; p_flush = 1'b0;
    p_wb_load = 1'b0; p_wb_addr = 4'd0; p_wb_data = 32'd0;
    rst = 1'b1;

    // Reset state.
    #12;
    check("reset_ex_valid", ex_valid, 1'b0);
    check("reset_ex_ctrl", ex_ctrl, 32'd0);
    check("reset_ex_a", ex_a_data, 16'd0);
    check("reset_id_stall", id_stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // wbl wba wbd | vld ctrl dest sr1 sr2 | link ssel ua ub wd mr | stl fl | e_stall e_valid e_dest e_a e_b
    tv[0] = '{1'b1, 3'd3, 16'hBEEF, 1'b1, 32'h11, 3'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'hBEEF, 16'h0000};
    tv[1] = '{1'b1, 3'd5, 16'h1234, 1'b1, 32'h22, 3'd5, 3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h1234, 16'hBEEF};
    tv[2] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h33, 3'd2, 3'd5, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h1234, 16'hBEEF};
    tv[3] = '{1'b1, 3'd2, 16'h00AA, 1'b1, 32'h44, 3'd4, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000};
    tv[4] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h44, 3'd4, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0000, 16'h00AA};
    tv[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h55, 3'd0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 16'hBEEF, 16'h0000};
    tv[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 32'h66, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000};
    tv[7] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h77, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0000, 16'h0000};
    tv[8] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h88, 3'd3, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000};
    tv[9] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h88, 3'd3, 3'd6, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0000, 16'h1234};

    foreach (tv[i]) begin
      drive_vec(tv[i]);
      #1;
      check($sformatf("tv%0d_id_stall", i), id_stall, tv[i].e_stall);
      @(posedge clk); #1;
      check($sformatf("tv%0d_ex_valid", i), ex_valid, tv[i].e_valid);
      check($sformatf("tv%0d_ex_ctrl", i), ex_ctrl, tv[i].e_valid ? tv[i].ctrl : 32'd0);
      if (tv[i].e_valid) begin
        check($sformatf("tv%0d_ex_dest", i), ex_dest, tv[i].e_dest);
        check($sformatf("tv%0d_ex_a", i), ex_a_data, tv[i].e_a);
        check($sformatf("tv%0d_ex_b", i), ex_b_data, tv[i].e_b);
      end
    end

    // Capture a known instruction, then hold it with ex_stall for 3 cycles.
    clear_inputs();
    in_valid = 1'b1; in_ctrl = 32'hA5A5_0001; in_dest = 3'd1; in_sr1 = 3'd3; in_sr2 = 3'd5;
    in_writes_dest = 1'b1;
    @(posedge clk); #1;
    check("hold_setup_a", ex_a_data, 16'hBEEF);
    for (int k = 0; k < 3; k++) begin
      ex_stall = 1'b1; in_ctrl = $urandom; in_sr1 = 3'd2; in_dest = 3'd6;
      #1;
      check("hold_id_stall", id_stall, 1'b1);
      @(posedge clk); #1;
      check("hold_ex_valid", ex_valid, 1'b1);
      check("hold_ex_ctrl", ex_ctrl, 32'hA5A5_0001);
      check("hold_ex_dest", ex_dest, 3'd1);
      check("hold_ex_a", ex_a_data, 16'hBEEF);
      check("hold_ex_b", ex_b_data, 16'h1234);
    end

    // Asynchronous reset in the middle of a stalled cycle.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ex_valid", ex_valid, 1'b0);
    check("async_rst_ex_ctrl", ex_ctrl, 32'd0);
    #1;
    rst = 1'b0;
    clear_inputs();
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1; in_sr1 = 3'(2 * r); in_sr2 = 3'(2 * r + 1);
      @(posedge clk); #1;
      check($sformatf("rst_rf_r%0d", 2 * r), ex_a_data, 16'h0000);
      check($sformatf("rst_rf_r%0d", 2 * r + 1), ex_b_data, 16'h0000);
    end

    // Random run against the reference model, starting from a fresh reset.
    clear_inputs();
    rst = 1'b1; #1; rst = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_valid = 1'b0; m_wd = 1'b0; m_mr = 1'b0; m_ctrl = 32'd0; m_dest = 3'd0;
    m_a = 16'h0000; m_b = 16'h0000;
    for (int n = 0; n < 400; n++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      in_ctrl        = $urandom;
      in_dest        = 3'($urandom_range(0, 7));
      in_sr1         = 3'($urandom_range(0, 7));
      in_sr2         = 3'($urandom_range(0, 7));
      in_dest_link   = ($urandom_range(0, 5) == 0);
      in_store_sel   = ($urandom_range(0, 3) == 0);
      in_uses_a      = ($urandom_range(0, 3) != 0);
      in_uses_b      = ($urandom_range(0, 1) != 0);
      in_writes_dest = ($urandom_range(0, 3) != 0);
      in_mem_read    = ($urandom_range(0, 1) != 0);
      ex_stall       = ($urandom_range(0, 5) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      wb_load        = ($urandom_range(0, 1) != 0);
      wb_addr        = 3'($urandom_range(0, 7));
      wb_data        = 16'($urandom);

      aa = in_store_sel ? in_dest : in_sr1;
      hz = in_valid && m_valid && m_mr && m_wd &&
           ((in_uses_a && aa == m_dest) || (in_uses_b && in_sr2 == m_dest));
      ra = (wb_load && wb_addr == aa) ? wb_data : m_rf[aa];
      rb = (wb_load && wb_addr == in_sr2) ? wb_data : m_rf[in_sr2];
      #1;
      check("rand_id_stall", id_stall, hz || ex_stall);

      if (flush || (!ex_stall && hz)) begin
        m_valid = 1'b0; m_ctrl = 32'd0; m_wd = 1'b0; m_mr = 1'b0;
      end else if (!ex_stall) begin
        m_valid = in_valid;
        m_ctrl  = in_valid ? in_ctrl : 32'd0;
        m_dest  = in_dest_link ? 3'd7 : in_dest;
        m_wd    = in_valid && in_writes_dest;
        m_mr    = in_valid && in_mem_read;
        m_a     = ra;
        m_b     = rb;
      end
      if (wb_load) m_rf[wb_addr] = wb_data;

      @(posedge clk); #1;
      check("rand_ex_valid", ex_valid, m_valid);
      check("rand_ex_ctrl", ex_ctrl, m_ctrl);
      check("rand_ex_writes", ex_writes_dest, m_wd);
      check("rand_ex_mem_read", ex_mem_read, m_mr);
      if (m_valid) begin
        check("rand_ex_dest", ex_dest, m_dest);
        check("rand_ex_a", ex_a_data, m_a);
        check("rand_ex_b", ex_b_data, m_b);
      end
    end
    clear_inputs();

    // Wide configuration: write R15, then read it back via both ports with link.
    p_wb_load = 1'b1; p_wb_addr = 4'd15; p_wb_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    p_wb_load = 1'b0;
    p_in_valid = 1'b1; p_in_ctrl = 8'h5A; p_in_dest_link = 1'b1; p_in_dest = 4'd0;
    p_in_sr1 = 4'd15; p_in_sr2 = 4'd15; p_in_uses_a = 1'b1; p_in_uses_b = 1'b1;
    p_in_writes_dest = 1'b1;
    #1;
    check("wide_id_stall", p_id_stall, 1'b0);
    @(posedge clk); #1;
    check("wide_ex_valid", p_ex_valid, 1'b1);
    check("wide_ex_ctrl", p_ex_ctrl, 8'h5A);
    check("wide_ex_dest", p_ex_dest, 4'd15);
    check("wide_ex_b", p_ex_b_data, 32'hDEAD_BEEF);
    check("wide_ex_a", p_ex_a_data, 32'hDEAD_BEEF);
    check("wide_ex_writes", p_ex_writes_dest, 1'b1);
    check("wide_ex_mem_read", p_ex_mem_read, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
